reg_load_arbiter: RTL and testbench

Shares one WIDTH-bit loadable/clearable register among N_REQ requesters, plus a dedicated clear requester. Arbitrates pending load requests, steers the winner's data into the register for exactly one load cycle, and returns a one-cycle acknowledge. Sits between the datapath requesters and the shared register, and is the only block that drives the register's load and clear controls.

---
 rtl/reg_load_arbiter_pkg.sv | 15 +
 rtl/reg_load_arbiter_reg.sv | 23 ++
 rtl/reg_load_arbiter.sv | 154 +++++++++++++++
 tb/tb_reg_load_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_load_arbiter_pkg.sv
// Shared types and defaults for the reg_load_arbiter block: FSM state encoding
// and default requester count / data width.
package reg_load_arbiter_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_CLEAR = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

endpackage

// File: rtl/reg_load_arbiter_reg.sv
// WIDTH-bit shared register with synchronous load and clear; load wins over clear.
module reg_ld_clr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (clr) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/reg_load_arbiter.sv
// Arbitrates N_REQ load requesters plus a clear requester onto one shared register.
// Define REG_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module reg_load_arbiter
    import reg_load_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] i_bus,
    input  logic                   clr_req,
    output logic [WIDTH-1:0]       a,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic                   clr_ack,
    output logic                   busy,
    output state_e                 state_o
);

    localparam int IW = $clog2(N_REQ);

    state_e          state_q, state_d;
    logic [IW-1:0]   win_q, win_d;
    logic            from_clr_q, from_clr_d;
    logic [IW-1:0]   pick_idx;
    logic            reg_load, reg_clr;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] slice [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_slice
        assign slice[k] = i_bus[k*WIDTH +: WIDTH];
    end

`ifdef REG_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] rr_idx;
    logic          rr_found;

    // Scan from ptr upward with wrap; first pending request wins.
    always_comb begin
        pick_idx = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(ptr_q) + i >= N_REQ) begin
                rr_idx = IW'(int'(ptr_q) + i - N_REQ);
            end else begin
                rr_idx = IW'(int'(ptr_q) + i);
            end
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                pick_idx = rr_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_ACK && !from_clr_q) begin
            ptr_d = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        pick_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_idx = IW'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            from_clr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            from_clr_q <= from_clr_d;
        end
    end

    // Clear beats loads; the winner is frozen on leaving IDLE.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        from_clr_d = from_clr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    from_clr_d = 1'b1;
                end else if (|req) begin
                    state_d    = ST_GRANT;
                    win_d      = pick_idx;
                    from_clr_d = 1'b0;
                end
            end
            ST_GRANT, ST_CLEAR: state_d = ST_ACK;
            ST_ACK:             state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt      = '0;
        ack      = '0;
        clr_ack  = 1'b0;
        reg_load = 1'b0;
        reg_clr  = 1'b0;
        busy     = (state_q != ST_IDLE);
        unique case (state_q)
            ST_GRANT: begin
                gnt[win_q] = 1'b1;
                reg_load   = 1'b1;
            end
            ST_CLEAR: reg_clr = 1'b1;
            ST_ACK: begin
                if (from_clr_q) begin
                    clr_ack = 1'b1;
                end else begin
                    ack[win_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ld_data = slice[win_q];
    assign state_o = state_q;

    reg_ld_clr #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .reset (reset),
        .load  (reg_load),
        .clr   (reg_clr),
        .d     (ld_data),
        .q     (a)
    );

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed and randomized bench for reg_load_arbiter against a transaction-level
// model; follows REG_ARB_RR_EN the same way as the design.
module tb_reg_load_arbiter;
    import reg_load_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] i_bus;
    logic           clr_req;
    logic [W-1:0]   a;
    logic [N-1:0]   gnt, ack;
    logic           clr_ack, busy;
    state_e         state_o;

    reg_load_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .req(req), .i_bus(i_bus), .clr_req(clr_req),
        .a(a), .gnt(gnt), .ack(ack), .clr_ack(clr_ack), .busy(busy), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit auto_drop = 1'b1;

    // Model: a transaction is idle (age 0), in its grant/clear cycle (1) or ack cycle (2).
    int         m_age = 0;
    bit         m_clr = 1'b0;
    int         m_w   = 0;
    logic [W-1:0] m_a = '0;
    int         m_ptr = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int           ack_cyc[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef REG_ARB_RR_EN
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
`else
        for (int i = 0; i < N; i++) if (r[i]) return i;
`endif
        return 0;
    endfunction

    task automatic tick();
        logic [N-1:0] e_gnt, e_ack;
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_age = 0; m_a = '0; m_ptr = 0; m_clr = 1'b0;
        end else if (m_age == 0) begin
            if (clr_req) begin
                m_age = 1; m_clr = 1'b1;
            end else if (req != '0) begin
                m_age = 1; m_clr = 1'b0; m_w = pick(req, m_ptr);
            end
        end else if (m_age == 1) begin
            m_a   = m_clr ? '0 : i_bus[m_w*W +: W];
            m_age = 2;
        end else begin
            m_age = 0;
            if (!m_clr) m_ptr = (m_w + 1) % N;
        end
        #1;
        e_gnt = (m_age == 1 && !m_clr) ? N'(1 << m_w) : '0;
        e_ack = (m_age == 2 && !m_clr) ? N'(1 << m_w) : '0;
        check("a", 16'(a), 16'(m_a));
        check("gnt", 16'(gnt), 16'(e_gnt));
        check("ack", 16'(ack), 16'(e_ack));
        check("clr_ack", 16'(clr_ack), 16'(m_age == 2 && m_clr));
        check("busy", 16'(busy), 16'(m_age != 0));
        check("idle", 16'(state_o == ST_IDLE), 16'(m_age == 0));
        for (int k = 0; k < N; k++) begin
            if (ack[k]) begin
                obs_q.push_back(W'(k));
                ack_cyc.push_back(cyc);
            end
        end
        if (auto_drop) begin
            for (int k = 0; k < N; k++) if (e_ack[k]) req[k] = 1'b0;
            if (m_age == 2 && m_clr) clr_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; clr_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        obs_q.delete(); ack_cyc.delete(); exp_q.delete();
    endtask

    task automatic compare_order(input string tag);
        check({tag, "_count"}, 16'(obs_q.size()), 16'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check(tag, 16'(obs_q.pop_front()), 16'(exp_q.pop_front()));
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; clr_req = 1'b0; i_bus = '0;

        // Reset state
        do_reset();
        check("rst_a", 16'(a), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);

        // Single load from requester 0
        auto_drop = 1'b1;
        i_bus[0 +: W] = 4'hA; req = 4'b0001;
        tick();
        check("t1_gnt", 16'(gnt), 16'h1);
        tick();
        check("t1_a", 16'(a), 16'hA);
        check("t1_ack", 16'(ack), 16'h1);
        tick();
        check("t1_busy_after", 16'(busy), 16'h0);

        // Requesters 1 and 3 held continuously
        do_reset();
        auto_drop = 1'b0;
        i_bus[1*W +: W] = 4'h3; i_bus[3*W +: W] = 4'hC; req = 4'b1010;
`ifdef REG_ARB_RR_EN
        exp_q = '{4'd1, 4'd3, 4'd1};
`else
        exp_q = '{4'd1, 4'd1, 4'd1};
`endif
        tick(); tick();
        check("hold_a0", 16'(a), 16'h3);
        for (int i = 0; i < 6; i++) tick();
        req = '0;
        tick(); tick();
        compare_order("hold_order");

        // Clear and load requested together: clear first
        auto_drop = 1'b1;
        i_bus[0 +: W] = 4'h5; req = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        check("clr_pre_a", 16'(a), 16'h5);
        clr_req = 1'b1; i_bus[2*W +: W] = 4'h7; req = 4'b0100;
        tick(); tick();
        check("clr_a", 16'(a), 16'h0);
        check("clr_ack_first", 16'(clr_ack), 16'h1);
        tick(); tick(); tick();
        check("clr_then_load_a", 16'(a), 16'h7);
        check("clr_then_ack", 16'(ack), 16'h4);
        tick();

        // Reset during GRANT aborts the load and returns ptr to 0
        i_bus[2*W +: W] = 4'h9; req = 4'b0100;
        tick();
        check("abort_gnt", 16'(gnt), 16'h4);
        reset = 1'b1; req = '0;
        tick();
        check("abort_ack", 16'(ack), 16'h0);
        check("abort_a", 16'(a), 16'h0);
        check("abort_idle", 16'(state_o == ST_IDLE), 16'h1);
        reset = 1'b0;
        obs_q.delete(); ack_cyc.delete();

        // All four requesting: order and 3-cycle ack spacing
        auto_drop = 1'b0;
        for (int k = 0; k < N; k++) i_bus[k*W +: W] = W'(k + 1);
        req = 4'b1111;
`ifdef REG_ARB_RR_EN
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
`else
        exp_q = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
`endif
        for (int i = 0; i < 14; i++) tick();
        req = '0;
        tick();
        for (int i = 1; i < ack_cyc.size(); i++) begin
            check("ack_spacing", 16'(ack_cyc[i] - ack_cyc[i-1]), 16'd3);
        end
        compare_order("all4_order");
        ack_cyc.delete();

        // Request dropped right after ack: single service, a holds
        auto_drop = 1'b1;
        i_bus[3*W +: W] = 4'hE; req = 4'b1000;
        for (int i = 0; i < 8; i++) tick();
        check("drop_services", 16'(obs_q.size()), 16'd1);
        check("drop_a_held", 16'(a), 16'hE);
        obs_q.delete(); ack_cyc.delete();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(0, 3) == 0) begin
                    i_bus[k*W +: W] = W'($urandom_range(0, 15));
                    req[k] = 1'b1;
                end
            end
            if (!clr_req && $urandom_range(0, 11) == 0) clr_req = 1'b1;
            if ($urandom_range(0, 149) == 0) reset = 1'b1;
            tick();
            if (reset) begin
                reset = 1'b0; req = '0; clr_req = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
